// File: rtl/chameleon_usart_pkg.sv
// Shared types and constants for the synchronous-clock USART receiver.
// The PARITY state exists only when CHAMELEON_USART_RX_PARITY_EN is defined.
package chameleon_usart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
`ifdef CHAMELEON_USART_RX_PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_STOP   = 2'd3
    } state_t;

endpackage

// File: rtl/chameleon_usart_rx_sync2.sv
// Two-flop synchronizer for one asynchronous input.
// The reset value is a parameter so an idle-high line shows no edge after reset.
module chameleon_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/chameleon_usart_rx.sv
// Synchronous-mode USART receiver: samples rxd on rising serial_clk, one-byte holding register.
// Define CHAMELEON_USART_RX_PARITY_EN to expect an even-parity bit after bit 7.
module chameleon_usart_rx
    import chameleon_usart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_clk,
    input  logic                 serial_rxd,
    output logic                 serial_cts_n,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_error,
    output logic                 overrun
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX  = '1;
    localparam logic [2:0]      LAST_BIT = 3'(DATA_BITS - 1);

    logic w_sclk_s;
    logic w_rxd_s;
    logic r_sclk_d;
    logic w_edge;
    logic w_timeout;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_cnt;
    logic [TO_W-1:0]      r_to_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_error;
    logic                 r_overrun;

    logic w_deliver;
    logic w_frame_err;
    logic w_shift_en;
    logic w_cnt_clr;
    logic w_stop_ok;

    chameleon_sync2 #(.RESET_VAL(LINE_IDLE)) u_sync_clk (
        .clk   (clk),
        .reset (reset),
        .i_d   (serial_clk),
        .o_q   (w_sclk_s)
    );

    chameleon_sync2 #(.RESET_VAL(LINE_IDLE)) u_sync_rxd (
        .clk   (clk),
        .reset (reset),
        .i_d   (serial_rxd),
        .o_q   (w_rxd_s)
    );

    always_ff @(posedge clk) begin
        if (reset) r_sclk_d <= LINE_IDLE;
        else       r_sclk_d <= w_sclk_s;
    end

    assign w_edge = w_sclk_s & ~r_sclk_d;
    // A real edge in the terminal cycle keeps the frame alive.
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_LAST) && !w_edge;

`ifdef CHAMELEON_USART_RX_PARITY_EN
    logic r_par_err;
    logic w_par_en;
    assign w_stop_ok = w_rxd_s & ~r_par_err;
`else
    assign w_stop_ok = w_rxd_s;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_deliver   = 1'b0;
        w_frame_err = 1'b0;
        w_shift_en  = 1'b0;
        w_cnt_clr   = 1'b0;
`ifdef CHAMELEON_USART_RX_PARITY_EN
        w_par_en    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_edge && !w_rxd_s) begin
                    w_state_nxt = ST_DATA;
                    w_cnt_clr   = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_edge) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == LAST_BIT) begin
`ifdef CHAMELEON_USART_RX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef CHAMELEON_USART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_edge) begin
                    w_par_en    = 1'b1;
                    w_state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_edge) begin
                    w_state_nxt = ST_IDLE;
                    w_deliver   = w_stop_ok;
                    w_frame_err = ~w_stop_ok;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_timeout) begin
            w_state_nxt = ST_IDLE;
            w_frame_err = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_to_cnt      <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_frame_err;
            r_overrun     <= 1'b0;

            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_edge || r_state == ST_IDLE) r_to_cnt <= '0;
            else if (r_to_cnt != TO_MAX)      r_to_cnt <= r_to_cnt + 1'b1;

            // A simultaneous consume frees the holding register for the new byte.
            if (w_deliver) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef CHAMELEON_USART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)          r_par_err <= 1'b0;
        else if (w_cnt_clr) r_par_err <= 1'b0;
        else if (w_par_en)  r_par_err <= (^r_shift) ^ w_rxd_s;
    end
`endif

    assign rx_data      = r_data;
    assign rx_valid     = r_valid;
    assign serial_cts_n = r_valid;
    assign frame_error  = r_frame_error;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_chameleon_usart_rx.sv
// Bench for chameleon_usart_rx: directed scenarios plus randomized frames against an event-level model.
// Parity scenarios follow CHAMELEON_USART_RX_PARITY_EN when it is defined.
module tb_chameleon_usart_rx;

    localparam int TO   = 16;
    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_clk;
    logic       serial_rxd;
    logic       serial_cts_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_error;
    logic       overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int n_fe, n_ov, n_vcyc, n_cts_bad;
    logic [7:0] acc_q[$];

    always #5 clk = ~clk;

    chameleon_usart_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_clk   (serial_clk),
        .serial_rxd   (serial_rxd),
        .serial_cts_n (serial_cts_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .frame_error  (frame_error),
        .overrun      (overrun)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Handshakes complete at the next posedge; inputs only change at posedge+2.
    always @(negedge clk) begin
        if (serial_cts_n !== rx_valid) n_cts_bad++;
        if (frame_error === 1'b1) n_fe++;
        if (overrun === 1'b1) n_ov++;
        if (rx_valid === 1'b1) n_vcyc++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) acc_q.push_back(rx_data);
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clr_mon;
        n_fe = 0;
        n_ov = 0;
        n_vcyc = 0;
        acc_q.delete();
    endtask

    task automatic send_bit(input logic b);
        serial_rxd = b;
        repeat (HALF) tick;
        serial_clk = 1'b1;
        repeat (HALF) tick;
        serial_clk = 1'b0;
    endtask

    task automatic send_body(input logic [7:0] d, input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef CHAMELEON_USART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        send_body(d, par_flip);
        send_bit(stop_b);
        repeat (2) tick;
    endtask

    task automatic drain;
        rx_ready = 1'b1;
        repeat (3) tick;
        rx_ready = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        serial_clk = 1'b0;
        serial_rxd = 1'b1;
        rx_ready = 1'b0;
        repeat (3) tick;
        n_tests++;
        if ({rx_data, rx_valid, serial_cts_n, frame_error, overrun} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%0h v=%0b cts=%0b fe=%0b ov=%0b, want all 0",
                     rx_data, rx_valid, serial_cts_n, frame_error, overrun);
        end
        reset = 1'b0;
        repeat (3) tick;
        clr_mon();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        repeat (2) tick;
        reset = 1'b0;
        repeat (5) tick;
        n_tests++;
        if (n_fe !== 0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midframe: got fe_pulses=%0d valid=%0b, want 0 and 0", n_fe, rx_valid);
        end
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0);
        rx_ready = 1'b0;
        n_tests++;
        if (acc_q.size() != 1) begin
            n_fail++;
            $display("FAIL reset_next_frame: got %0d bytes, want 1", acc_q.size());
        end else if (acc_q[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_next_frame: got %0h, want 5a", acc_q[0]);
        end
    endtask

    task automatic test_basic;
        clr_mon();
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        rx_ready = 1'b0;
        n_tests++;
        if (acc_q.size() != 1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d bytes, want 1", acc_q.size());
        end else if (acc_q[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL basic_data: got %0h, want a5", acc_q[0]);
        end
        n_tests++;
        if (n_vcyc !== 1 || n_fe !== 0 || n_ov !== 0) begin
            n_fail++;
            $display("FAIL basic_pulses: got valid_cycles=%0d fe=%0d ov=%0d, want 1 0 0", n_vcyc, n_fe, n_ov);
        end
    endtask

    task automatic test_overrun;
        clr_mon();
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        n_tests++;
        if (rx_data !== 8'h11 || rx_valid !== 1'b1 || serial_cts_n !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_hold: got data=%0h v=%0b cts=%0b, want 11 1 1", rx_data, rx_valid, serial_cts_n);
        end
        n_tests++;
        if (n_ov !== 1 || n_fe !== 0) begin
            n_fail++;
            $display("FAIL overrun_pulse: got ov=%0d fe=%0d, want 1 0", n_ov, n_fe);
        end
        drain();
        n_tests++;
        if (acc_q.size() != 1 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain: got bytes=%0d valid=%0b, want 1 0", acc_q.size(), rx_valid);
        end else if (acc_q[0] !== 8'h11) begin
            n_fail++;
            $display("FAIL overrun_drain: got %0h, want 11", acc_q[0]);
        end
    endtask

    task automatic test_stop_error;
        clr_mon();
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0);
        n_tests++;
        if (n_fe !== 1 || n_vcyc !== 0) begin
            n_fail++;
            $display("FAIL stop_error: got fe=%0d valid_cycles=%0d, want 1 0", n_fe, n_vcyc);
        end
        send_frame(8'h7E, 1'b1, 1'b0);
        rx_ready = 1'b0;
        n_tests++;
        if (acc_q.size() != 1) begin
            n_fail++;
            $display("FAIL stop_recover: got %0d bytes, want 1", acc_q.size());
        end else if (acc_q[0] !== 8'h7E) begin
            n_fail++;
            $display("FAIL stop_recover: got %0h, want 7e", acc_q[0]);
        end
    endtask

    task automatic test_timeout;
        int seen;
        clr_mon();
        rx_ready = 1'b1;
        seen = 0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        serial_rxd = 1'b1;
        repeat (HALF) tick;
        serial_clk = 1'b1;
        // Rise -> 2 sync stages -> edge cycle clears the counter -> TO cycles -> registered pulse.
        for (int k = 1; k <= 60; k++) begin
            tick;
            if (k == HALF) serial_clk = 1'b0;
            if (frame_error === 1'b1 && seen == 0) seen = k;
        end
        n_tests++;
        if (seen != TO + 3) begin
            n_fail++;
            $display("FAIL timeout_latency: got pulse after %0d cycles, want %0d", seen, TO + 3);
        end
        n_tests++;
        if (n_fe !== 1 || n_vcyc !== 0) begin
            n_fail++;
            $display("FAIL timeout_pulses: got fe=%0d valid_cycles=%0d, want 1 0", n_fe, n_vcyc);
        end
        send_frame(8'h01, 1'b1, 1'b0);
        rx_ready = 1'b0;
        n_tests++;
        if (acc_q.size() != 1) begin
            n_fail++;
            $display("FAIL timeout_recover: got %0d bytes, want 1", acc_q.size());
        end else if (acc_q[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL timeout_recover: got %0h, want 01", acc_q[0]);
        end
    endtask

    task automatic test_same_cycle;
        logic ok55;
        clr_mon();
        rx_ready = 1'b0;
        send_frame(8'h55, 1'b1, 1'b0);
        send_body(8'hAA, 1'b0);
        serial_rxd = 1'b1;
        repeat (HALF) tick;
        serial_clk = 1'b1;
        tick;
        ok55 = (rx_valid === 1'b1 && rx_data === 8'h55);
        tick;
        ok55 = ok55 && (rx_valid === 1'b1 && rx_data === 8'h55);
        rx_ready = 1'b1;
        n_tests++;
        if (!ok55) begin
            n_fail++;
            $display("FAIL same_cycle_hold: got data=%0h v=%0b before delivery, want 55 1", rx_data, rx_valid);
        end
        tick;
        rx_ready = 1'b0;
        n_tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hAA) begin
            n_fail++;
            $display("FAIL same_cycle_load: got data=%0h v=%0b, want aa 1", rx_data, rx_valid);
        end
        repeat (HALF - 3) tick;
        serial_clk = 1'b0;
        repeat (3) tick;
        n_tests++;
        if (n_ov !== 0 || rx_valid !== 1'b1 || rx_data !== 8'hAA) begin
            n_fail++;
            $display("FAIL same_cycle_ov: got ov=%0d data=%0h v=%0b, want 0 aa 1", n_ov, rx_data, rx_valid);
        end
        drain();
    endtask

`ifdef CHAMELEON_USART_RX_PARITY_EN
    task automatic test_parity;
        clr_mon();
        rx_ready = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1);
        n_tests++;
        if (n_fe !== 1 || acc_q.size() != 0) begin
            n_fail++;
            $display("FAIL parity_bad: got fe=%0d bytes=%0d, want 1 0", n_fe, acc_q.size());
        end
        send_frame(8'h03, 1'b1, 1'b0);
        rx_ready = 1'b0;
        n_tests++;
        if (acc_q.size() != 1 || n_fe !== 1) begin
            n_fail++;
            $display("FAIL parity_good: got bytes=%0d fe=%0d, want 1 1", acc_q.size(), n_fe);
        end else if (acc_q[0] !== 8'h03) begin
            n_fail++;
            $display("FAIL parity_good: got %0h, want 03", acc_q[0]);
        end
    endtask
`endif

    task automatic test_random;
        logic [7:0] exp_q[$];
        logic       hold_v;
        logic [7:0] hold_d;
        int         exp_fe, exp_ov;
        logic [7:0] d;
        logic       r, bad_stop, par_flip, bad;
        clr_mon();
        hold_v = 1'b0;
        hold_d = 8'h00;
        exp_fe = 0;
        exp_ov = 0;
        for (int f = 0; f < 30; f++) begin
            d = 8'($urandom);
            r = 1'($urandom_range(0, 1));
            bad_stop = ($urandom_range(0, 7) == 0);
            par_flip = 1'b0;
`ifdef CHAMELEON_USART_RX_PARITY_EN
            par_flip = ($urandom_range(0, 7) == 0);
`endif
            bad = bad_stop | par_flip;
            rx_ready = r;
            tick;
            send_frame(d, ~bad_stop, par_flip);
            if (r && hold_v) begin
                exp_q.push_back(hold_d);
                hold_v = 1'b0;
            end
            if (bad) begin
                exp_fe++;
            end else if (r) begin
                exp_q.push_back(d);
            end else if (hold_v) begin
                exp_ov++;
            end else begin
                hold_v = 1'b1;
                hold_d = d;
            end
        end
        drain();
        if (hold_v) exp_q.push_back(hold_d);
        n_tests++;
        if (acc_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d bytes, want %0d", acc_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_tests++;
                if (acc_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random_byte[%0d]: got %0h, want %0h", i, acc_q[i], exp_q[i]);
                end
            end
        end
        n_tests++;
        if (n_fe !== exp_fe || n_ov !== exp_ov) begin
            n_fail++;
            $display("FAIL random_pulses: got fe=%0d ov=%0d, want %0d %0d", n_fe, n_ov, exp_fe, exp_ov);
        end
    endtask

    task automatic test_cts;
        n_tests++;
        if (n_cts_bad !== 0) begin
            n_fail++;
            $display("FAIL cts_tracks_valid: got %0d differing cycles, want 0", n_cts_bad);
        end
    endtask

    initial begin
        n_cts_bad = 0;
        clr_mon();
        test_reset();
        test_basic();
        test_overrun();
        test_stop_error();
        test_timeout();
        test_same_cycle();
`ifdef CHAMELEON_USART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_cts();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
